// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: holds renamed instructions, wakes
// operands from the CDB, and issues the oldest ready entry (by ROB age) to
// one functional unit. Supports partial flush of entries younger than a
// mispredicted branch.

package types_pkg;
  typedef struct packed {
    logic        valid;
    logic [8:0]  op;
    logic [31:0] imm;
    logic [7:0]  pd;
    logic [7:0]  ps1;
    logic        ps1_ready;
    logic [7:0]  ps2;
    logic        ps2_ready;
    logic [3:0]  rob_index;
    logic        ready;
    logic        fu_ready;
  } rs_data;  // 74 bits
endpackage

// One scheduler slot: storage, valid bit and operand wakeup.
module rs_entry
  import types_pkg::*;
#(
  parameter int CDB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_i,
  input  rs_data                     alloc_data_i,
  input  logic [CDB_PORTS-1:0]       cdb_valid_i,
  input  logic [CDB_PORTS-1:0][7:0]  cdb_tag_i,
  input  logic                       kill_i,
  input  logic                       clr_i,
  output logic                       vld_o,
  output rs_data                     data_o
);
  logic   vld_q;
  rs_data data_q;
  logic   hit1, hit2;

  // Match this slot's source tags against every live CDB port.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid_i[p] && cdb_tag_i[p] == data_q.ps1) hit1 = 1'b1;
      if (cdb_valid_i[p] && cdb_tag_i[p] == data_q.ps2) hit2 = 1'b1;
    end
  end

  // Allocate, retire (issue/kill) or wake; ready bits only ever set.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (alloc_i) begin
      vld_q  <= 1'b1;
      data_q <= alloc_data_i;
    end else if (vld_q) begin
      if (kill_i || clr_i) begin
        vld_q <= 1'b0;
      end else begin
        if (hit1) data_q.ps1_ready <= 1'b1;
        if (hit2) data_q.ps2_ready <= 1'b1;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
endmodule

module rs_issue_scheduler
  import types_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          disp_valid,
  input  rs_data                        disp_data,
  output logic                          disp_ready,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS-1:0][7:0]     cdb_tag,
  input  logic [3:0]                    rob_head,
  input  logic                          flush_valid,
  input  logic [3:0]                    flush_rob_tag,
  output logic                          issue_valid,
  output rs_data                        issue_data,
  input  logic                          issue_ready,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]           vld, elig, kill, alloc, clr;
  rs_data [DEPTH-1:0]         ent;
  logic [DEPTH-1:0][3:0]      ent_age;
  logic [3:0]                 flush_age, sel_age;
  logic [IW-1:0]              sel_idx, free_idx;
  logic                       any_elig, disp_fire, issue_fire;
  logic [CW-1:0]              kill_cnt, count_q, count_d;
  rs_data                     alloc_data, sel_data;
  logic                       byp1, byp2;

  assign disp_ready = (count_q < CW'(DEPTH)) && !flush_valid && !reset;
  assign disp_fire  = disp_valid && disp_ready;
  assign flush_age  = flush_rob_tag - rob_head;

  // Per-entry age (4-bit wrap), eligibility and flush kill.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_age[i] = ent[i].rob_index - rob_head;
      elig[i]    = vld[i] && ent[i].ps1_ready && ent[i].ps2_ready;
      kill[i]    = flush_valid && vld[i] && (ent_age[i] > flush_age);
    end
  end

  // Oldest eligible entry; strict compare keeps the lowest index on ties.
  always_comb begin
    any_elig = 1'b0;
    sel_idx  = '0;
    sel_age  = 4'hF;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!any_elig || ent_age[i] < sel_age)) begin
        any_elig = 1'b1;
        sel_idx  = IW'(i);
        sel_age  = ent_age[i];
      end
    end
  end

  assign issue_valid = any_elig && !flush_valid;
  assign issue_fire  = issue_valid && issue_ready;

  // Presented entry carries forced ready flags; zero when nothing issues.
  always_comb begin
    sel_data          = ent[sel_idx];
    sel_data.ready    = 1'b1;
    sel_data.fu_ready = 1'b1;
    issue_data        = issue_valid ? sel_data : '0;
  end

  // Lowest free slot, killed-entry count, and same-cycle CDB bypass.
  always_comb begin
    free_idx = '0;
    kill_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!vld[i]) free_idx = IW'(i);
    for (int i = 0; i < DEPTH; i++)
      kill_cnt = kill_cnt + CW'(kill[i]);
    byp1 = 1'b0;
    byp2 = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (cdb_valid[p] && cdb_tag[p] == disp_data.ps1) byp1 = 1'b1;
      if (cdb_valid[p] && cdb_tag[p] == disp_data.ps2) byp2 = 1'b1;
    end
    alloc_data           = disp_data;
    alloc_data.valid     = 1'b1;
    alloc_data.ready     = 1'b0;
    alloc_data.fu_ready  = 1'b0;
    alloc_data.ps1_ready = disp_data.ps1_ready || (disp_data.ps1 == 8'd0) || byp1;
    alloc_data.ps2_ready = disp_data.ps2_ready || (disp_data.ps2 == 8'd0) || byp2;
  end

  // Per-slot strobes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      alloc[i] = disp_fire && (free_idx == IW'(i));
      clr[i]   = issue_fire && (sel_idx == IW'(i));
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      rs_entry #(.CDB_PORTS(CDB_PORTS)) u_ent (
        .clk          (clk),
        .reset        (reset),
        .alloc_i      (alloc[g]),
        .alloc_data_i (alloc_data),
        .cdb_valid_i  (cdb_valid),
        .cdb_tag_i    (cdb_tag),
        .kill_i       (kill[g]),
        .clr_i        (clr[g]),
        .vld_o        (vld[g]),
        .data_o       (ent[g])
      );
    end
  endgenerate

  assign count_d = count_q + CW'(disp_fire) - CW'(issue_fire) - kill_cnt;

  // Occupancy counter tracks dispatch, issue and flush kills.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Reservation-station issue scheduler for the out-of-order core, placed between dispatch and one functional unit.
- Holds up to DEPTH renamed instructions in `types_pkg::rs_data` form.
- Wakes source operands from the common data bus (CDB).
- Each cycle, selects the oldest fully-ready entry in program order (relative to the ROB head) and issues it to the FU with a valid/ready handshake.
- Supports a partial flush that kills every entry younger than a mispredicted ROB tag.

## Interface
Parameters
- DEPTH, 8: number of entries. Power of two, 2..16.
- CDB_PORTS, 2: number of wakeup broadcast ports.

Ports
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- disp_valid  in  1  dispatch request.
- disp_data  in  rs_data (74)  instruction to insert; its valid/ready/fu_ready fields are ignored on input.
- disp_ready  out  1  scheduler can accept a dispatch this cycle.
- cdb_valid  in  CDB_PORTS  per-port broadcast valid.
- cdb_tag  in  CDB_PORTS x 8  physical register tag being written.
- rob_head  in  4  ROB index of the oldest in-flight instruction; age reference.
- flush_valid  in  1  branch mispredict recovery.
- flush_rob_tag  in  4  ROB index of the mispredicted branch; the branch itself survives.
- issue_valid  out  1  issue_data holds a selected ready entry.
- issue_data  out  rs_data (74)  selected entry; valid, ps1_ready, ps2_ready, ready are all 1.
- issue_ready  in  1  FU accepts issue_data.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Storage.** DEPTH entries of rs_data plus a per-entry valid bit. No compaction; age is derived from rob_index only.
- **Age.** age(e) = (e.rob_index − rob_head) mod 16, as a 4-bit unsigned wrap-around subtraction. A smaller age means older.
- **Allocation.** On disp_valid && disp_ready, write the lowest-index free entry.
  - ps1_ready/ps2_ready are set if the incoming ready bit is 1, or the tag is 0 (x0), or the tag matches any valid CDB port in the same cycle (same-cycle bypass).
- **Wakeup.** For every valid entry and every valid CDB port, a tag match sets that operand's ready bit. Ready bits never clear while the entry lives.
- **Eligibility.** An entry is eligible when valid && ps1_ready && ps2_ready, evaluated on registered state.
- **Select.** Combinational. Choose the eligible entry with the smallest age; break ties (not expected) by lowest index.
  - issue_valid = any eligible && !flush_valid.
  - issue_data is the selected entry with ready=1 and fu_ready=1.
- **Issue.** On issue_valid && issue_ready, clear the selected entry's valid bit at the clock edge.
  - While issue_ready is 0, the selection may change between cycles if an older entry becomes eligible. The FU latches only on handshake.
- **Flush.** On flush_valid, clear every valid entry with age(e) > age(flush_rob_tag).
  - No dispatch or issue occurs in a flush cycle: disp_ready=0 and issue_valid=0.
  - CDB wakeups to surviving entries still apply.
- **Count.** count = popcount of the valid bits, kept as a registered counter. Per cycle it changes by +1 on dispatch, −1 on issue, and −(killed) on flush.
- **disp_ready** = (count < DEPTH) && !flush_valid && !reset. A slot freed by issue in the same cycle is not reusable until the next cycle.

## Timing
- **Reset.** All entry valid bits clear, count=0, issue_valid=0, issue_data=0. disp_ready=0 while reset is high and 1 on the first cycle after.
- **Dispatch to issue.** An entry dispatched at edge N with both operands ready can issue in cycle N+1, i.e. 1 cycle minimum.
- **Wakeup to issue.** A CDB broadcast in cycle N sets ready at edge N; the entry is eligible in cycle N+1.
- **Simultaneous events.** Dispatch and issue in the same cycle keep count unchanged. A CDB hit on an entry issued that same cycle is ignored.
- **Full.** With count=DEPTH, disp_ready=0 and a dispatch presented by the upstream is held there.
- **Wrap-around.** Age stays correct across rob_index 15→0. Example: rob_head=14, rob_index 1 has age 3, older than rob_index 5 with age 7.
- **Reset mid-operation.** Reset overrides dispatch, issue and flush in that cycle; all entries are lost.

## Test plan
- **Reset then empty.** Assert reset for 2 cycles → count=0, issue_valid=0, disp_ready=0 during reset and 1 after.
- **Fill and full.** Dispatch 8 entries (rob 0..7) with ps1/ps2 not ready → count=8, disp_ready=0, issue_valid=0. A ninth disp_valid is not accepted.
- **Wakeup and oldest-first.** rob_head=0, entries rob 3 and rob 1 both waiting on tag 0x21. Broadcast 0x21 → next cycle issue rob 1, then rob 3 on the following handshake.
- **Same-cycle bypass.** Dispatch with ps1=0x30 not ready while cdb_tag[0]=0x30 valid, ps2=0 → issues the following cycle.
- **Wrap-around age.** rob_head=14; ready entries rob 5 and rob 1 → rob 1 issues first.
- **Flush.** rob_head=2; entries rob 3,4,6,9; flush_rob_tag=4 → rob 6 and 9 removed, count 4→2, issue_valid=0 in the flush cycle, rob 3 issues next.
